// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART byte-stream command engine that loads/dumps data RAM through memory port B.
// Latency: mem_we pulses the cycle after the 4th data byte of a word; read words stream at 5 cycles/word with tx_ready high.
// Backpressure: tx bytes held until tx_ready; rx has none, so bytes arriving in RLOAD/RSEND/STAT are dropped with rx_overrun.
// Ports: clk, rst (async, active-high); rx_data/rx_valid byte input; tx_data/tx_valid/tx_ready byte output;
//        mem_we/mem_addr/mem_wdata/mem_rdata port-B access (rdata combinational from addr); busy, rx_overrun status.
module uart_mem_loader #(
  parameter int          ADDR_W   = 10,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              rx_overrun
);

  localparam logic [7:0]        OP_WR    = 8'h57;
  localparam logic [7:0]        OP_RD    = 8'h52;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_RLOAD, S_RSEND, S_STAT} state_t;

  state_t              state_q, state_d;
  logic                is_rd_q, is_rd_d;
  logic [7:0]          hdr_q, hdr_d;     // previous header byte (ADDR_HI or CNT_HI)
  logic [1:0]          idx_q, idx_d;     // header / data / tx byte index
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         dat_q, dat_d;     // write assembly or read shift register
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      hdr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      dat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      hdr_q      <= hdr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dat_q      <= dat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    hdr_d      = hdr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dat_d      = dat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ovr_d      = rx_valid && (state_q == S_RLOAD || state_q == S_RSEND || state_q == S_STAT);

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_rd_d = (rx_data == OP_RD);
            idx_d   = '0;
            state_d = S_HDR;
          end else begin
            tx_data_d  = NAK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = S_STAT;
          end
        end
      end
      S_HDR: begin
        if (rx_valid) begin
          hdr_d = rx_data;
          idx_d = idx_q + 2'd1;
          // Address is taken from the low ADDR_W bits of {ADDR_HI, ADDR_LO}.
          if (idx_q == 2'd1) addr_d = ADDR_W'({hdr_q, rx_data});
          if (idx_q == 2'd3) begin
            cnt_d = {hdr_q, rx_data};
            idx_d = '0;
            if (cnt_d == 16'd0) begin
              tx_data_d  = ACK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = S_STAT;
            end else if (is_rd_q) begin
              state_d = S_RLOAD;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
      end
      S_WDATA: begin
        // Address/count advance in the cycle after the write pulse.
        if (we_q) begin
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            tx_data_d  = ACK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = S_STAT;
          end
        end
        // Bytes keep arriving during the pulse cycle; byte 0 ends up in bits [7:0].
        if (rx_valid && state_d == S_WDATA) begin
          dat_d = {rx_data, dat_q[31:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wdata_d = {rx_data, dat_q[31:8]};
            we_d    = 1'b1;
          end
        end
      end
      S_RLOAD: begin
        dat_d      = mem_rdata;
        tx_data_d  = mem_rdata[7:0];
        tx_valid_d = 1'b1;
        idx_d      = '0;
        state_d    = S_RSEND;
      end
      S_RSEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == 2'd3) begin
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              tx_data_d = ACK_BYTE;
              state_d   = S_STAT;
            end else begin
              tx_valid_d = 1'b0;
              state_d    = S_RLOAD;
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            dat_d     = {8'h00, dat_q[31:8]};
            tx_data_d = dat_q[15:8];
          end
        end
      end
      S_STAT: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid, mem_we, busy, rx_overrun;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  uart_mem_loader #(.ADDR_W(10), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .rx_overrun(rx_overrun));

  always #5 clk = ~clk;

  // Memory behind port B
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
  logic [7:0]  exp_tx[$];
  logic [41:0] exp_wr[$];
  logic [7:0]  cmd[$];
  logic [31:0] wq[$];

  // Observed traffic
  logic [7:0]  got_tx[$];
  logic [41:0] got_wr[$];
  int          we_cyc[$];
  int          rx_cyc[$];
  int          stall_viol, we_viol, ovr_cnt;
  logic        prev_stall = 1'b0, prev_we = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    tx_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (mem_we) begin
        got_wr.push_back({mem_addr, mem_wdata});
        we_cyc.push_back(cyc);
        if (prev_we) we_viol++;
      end
      prev_we = mem_we;
      if (rx_valid) rx_cyc.push_back(cyc);
      if (rx_overrun) ovr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    exp_tx.delete(); exp_wr.delete(); got_tx.delete(); got_wr.delete();
    we_cyc.delete(); rx_cyc.delete(); cmd.delete();
    stall_viol = 0; we_viol = 0; ovr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // gap < 0 means a random 0..3 idle cycles between bytes
  task automatic send_cmd(input int gap);
    foreach (cmd[i]) begin
      send_byte(cmd[i]);
      if (i != cmd.size() - 1) tick(gap < 0 ? int'($urandom_range(0, 3)) : gap);
    end
    cmd.delete();
  endtask

  task automatic do_write(input logic [15:0] a, input int gap);
    logic [15:0] c;
    logic [31:0] w;
    c = 16'(wq.size());
    cmd.push_back(8'h57); cmd.push_back(a[15:8]); cmd.push_back(a[7:0]);
    cmd.push_back(c[15:8]); cmd.push_back(c[7:0]);
    foreach (wq[i]) begin
      w = wq[i];
      cmd.push_back(w[7:0]); cmd.push_back(w[15:8]); cmd.push_back(w[23:16]); cmd.push_back(w[31:24]);
      exp_wr.push_back({10'((int'(a) + i) % 1024), w});
      ref_mem[(int'(a) + i) % 1024] = w;
    end
    exp_tx.push_back(8'h06);
    send_cmd(gap);
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input int gap);
    logic [15:0] c;
    logic [31:0] w;
    c = 16'(n);
    cmd.push_back(8'h52); cmd.push_back(a[15:8]); cmd.push_back(a[7:0]);
    cmd.push_back(c[15:8]); cmd.push_back(c[7:0]);
    for (int i = 0; i < n; i++) begin
      w = ref_mem[(int'(a) + i) % 1024];
      exp_tx.push_back(w[7:0]); exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[23:16]); exp_tx.push_back(w[31:24]);
    end
    exp_tx.push_back(8'h06);
    send_cmd(gap);
  endtask

  // Counts busy cycles until the engine returns to IDLE, bounded.
  task automatic wait_done(output int nb);
    bit done = 0;
    nb = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
      nb++;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL wait_idle busy still high after %0d cycles", nb); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    checks += 7;
    if (mem_we !== 1'b0)     begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    if (mem_addr !== 10'h0)  begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    if (tx_data !== 8'h0)    begin failures++; $display("FAIL rst_tx_data got=%h exp=0", tx_data); end
    if (tx_valid !== 1'b0)   begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rst_rx_overrun got=%b exp=0", rx_overrun); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_write_two();
    int nb;
    clr(); rdy_mode = 0;
    wq = '{32'hDEADBEEF, 32'h11223344};
    do_write(16'h0010, -1);
    wait_done(nb);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL w2_wr_len got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL w2_wr[%0d] got=%h exp=%h", i, got_wr[i], exp_wr[i]); end end
    checks++;
    if (got_tx.size() != 1 || got_tx[0] !== 8'h06) begin failures++; $display("FAIL w2_ack got_n=%0d exp=06", got_tx.size()); end
    checks++;
    if (we_viol != 0) begin failures++; $display("FAIL w2_we_width got=%0d exp=0", we_viol); end
  endtask

  task automatic test_read_stall();
    int nb;
    clr(); rdy_mode = 1;
    do_read(16'h0010, 2, -1);
    wait_done(nb);
    rdy_mode = 0;
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL rd_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rd_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
    checks += 2;
    if (stall_viol != 0) begin failures++; $display("FAIL rd_stall_stable got=%0d exp=0", stall_viol); end
    if (got_wr.size() != 0) begin failures++; $display("FAIL rd_no_we got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_wrap();
    int nb;
    clr(); rdy_mode = 0;
    wq = '{$urandom(), $urandom()};
    do_write(16'h03FF, -1); wait_done(nb);
    wq = '{$urandom()};
    do_write(16'hFC00, 0); wait_done(nb);
    do_read(16'h03FF, 2, 0); wait_done(nb);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL wrap_wr_len got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, got_wr[i], exp_wr[i]); end end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL wrap_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL wrap_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
  endtask

  task automatic test_edge_cmds();
    int nb;
    clr(); rdy_mode = 0;
    send_byte(8'h41); exp_tx.push_back(8'h15);
    wait_done(nb);
    checks++;
    if (nb != 1) begin failures++; $display("FAIL nak_busy_cycles got=%0d exp=1", nb); end
    wq.delete();
    do_write(16'h0123, 0); wait_done(nb);
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL edge_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL edge_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
    checks++;
    if (got_wr.size() != 0) begin failures++; $display("FAIL cnt0_no_we got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_overrun();
    int nb;
    clr(); rdy_mode = 2; tick(1);
    do_read(16'(($urandom_range(0, 1) == 1) ? 16'h0010 : 16'h03FF), 1, 0);
    tick(2);
    send_byte(8'h57);
    tick(1); rdy_mode = 0;
    wait_done(nb);
    checks += 2;
    if (ovr_cnt != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    if (got_wr.size() != 0) begin failures++; $display("FAIL ovr_no_we got=%0d exp=0", got_wr.size()); end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL ovr_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL ovr_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
  endtask

  task automatic test_reset_mid();
    int nb;
    clr(); rdy_mode = 0;
    cmd = '{8'h57, 8'h00, 8'h20, 8'h00, 8'h01, 8'($urandom()), 8'($urandom())};
    send_cmd(1);
    rst = 1'b1; #1;
    checks += 2;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got=%b exp=0", tx_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tick(2); rst = 1'b0; tick(6);
    checks++;
    if (got_wr.size() != 0) begin failures++; $display("FAIL rstmid_no_we got=%0d exp=0", got_wr.size()); end
    wq = '{$urandom()};
    do_write(16'h0020, -1); wait_done(nb);
    do_read(16'h0020, 1, 0); wait_done(nb);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rstmid_wr_len got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rstmid_wr[%0d] got=%h exp=%h", i, got_wr[i], exp_wr[i]); end end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL rstmid_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rstmid_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
  endtask

  task automatic test_back_to_back();
    int nb;
    logic [15:0] a;
    clr(); rdy_mode = 0;
    a = 16'($urandom());
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom());
    do_write(a, 0); wait_done(nb);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL b2b_wr_len got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks += 2;
      if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL b2b_wr[%0d] got=%h exp=%h", i, got_wr[i], exp_wr[i]); end
      if (we_cyc[i] != rx_cyc[8 + 4 * i] + 1) begin failures++; $display("FAIL b2b_we_cycle[%0d] got=%0d exp=%0d", i, we_cyc[i], rx_cyc[8 + 4 * i] + 1); end
    end
    do_read(a, 8, 0); wait_done(nb);
    checks++;
    if (nb != 5 * 8 + 1) begin failures++; $display("FAIL b2b_read_cycles got=%0d exp=%0d", nb, 5 * 8 + 1); end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL b2b_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL b2b_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
  endtask

  task automatic test_random();
    int nb;
    clr(); rdy_mode = 1;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) wq.push_back($urandom());
        do_write(16'($urandom()), -1);
      end else begin
        do_read(16'($urandom()), int'($urandom_range(1, 3)), -1);
      end
      wait_done(nb);
    end
    rdy_mode = 0;
    checks++;
    if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rnd_wr_len got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rnd_wr[%0d] got=%h exp=%h", i, got_wr[i], exp_wr[i]); end end
    checks++;
    if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL rnd_tx_len got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rnd_tx[%0d] got=%h exp=%h", i, got_tx[i], exp_tx[i]); end end
    checks++;
    if (stall_viol != 0) begin failures++; $display("FAIL rnd_stall_stable got=%0d exp=0", stall_viol); end
  endtask

  initial begin
    test_reset();
    test_write_two();
    test_read_stall();
    test_wrap();
    test_edge_cmds();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
